// File: rtl/fifo_burst_reader.sv
// Pops a programmed burst from a 1-cycle-latency FIFO into a 2-entry skid buffer and streams it out with last.
// Latency start->m_valid is 3 cycles; m_ready backpressure throttles pops so the skid buffer never overflows.
module fifo_burst_reader #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 i_clock,
    input  logic                 i_areset,
    input  logic                 i_start,
    input  logic [LEN_WIDTH-1:0] i_burst_len,
    output logic                 o_busy,
    output logic                 o_done,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    input  logic [WIDTH-1:0]     i_fifo_data,
    output logic                 o_m_valid,
    input  logic                 i_m_ready,
    output logic [WIDTH-1:0]     o_m_data,
    output logic                 o_m_last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_WIDTH-1:0] r_issue_cnt;
    logic [LEN_WIDTH-1:0] r_out_cnt;
    logic                 r_inflight;
    logic [1:0]           r_occ;
    logic [WIDTH-1:0]     r_buf0;
    logic [WIDTH-1:0]     r_buf1;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_rd_en;
    logic                 w_load;
    logic [2:0]           w_level;

    assign o_m_valid = (r_occ != 2'd0);
    assign o_m_data  = r_buf0;
    assign o_m_last  = o_m_valid && (r_out_cnt == LEN_WIDTH'(1));
    assign o_busy    = (r_state == ST_RUN);
    assign o_done    = (r_state == ST_DONE);

    assign w_pop  = o_m_valid && i_m_ready;
    assign w_push = r_inflight;
    assign w_load = (r_state == ST_IDLE) && i_start && (i_burst_len != '0);

    // Words already committed to the buffer (held + in flight) after this cycle's pop.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_rd_en = (r_state == ST_RUN) && !i_fifo_empty &&
                     (r_issue_cnt != '0) && (w_level < 3'd2);
    assign o_fifo_rd_en = w_rd_en;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_burst_len != '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (w_pop && o_m_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_load) begin
                r_issue_cnt <= i_burst_len;
                r_out_cnt   <= i_burst_len;
            end else begin
                if (w_rd_en) begin
                    r_issue_cnt <= r_issue_cnt - LEN_WIDTH'(1);
                end
                if (w_pop && (r_out_cnt != '0)) begin
                    r_out_cnt <= r_out_cnt - LEN_WIDTH'(1);
                end
            end
        end
    end

    // Head of the skid buffer is r_buf0; the pop rule guarantees a push never meets a full buffer.
    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                if (r_occ == 2'd2) begin
                    r_buf0 <= r_buf1;
                    if (w_push) begin
                        r_buf1 <= i_fifo_data;
                    end
                end else if (w_push) begin
                    r_buf0 <= i_fifo_data;
                end
            end else if (w_push) begin
                if (r_occ == 2'd0) begin
                    r_buf0 <= i_fifo_data;
                end else begin
                    r_buf1 <= i_fifo_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a 1-cycle-latency FIFO model; vectors are per-cycle bit masks.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        areset;
    logic        start;
    logic [7:0]  burst_len;
    logic        busy;
    logic        done;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        tb_flush = 1'b0;
    logic [31:0] exp_dat  [16];
    logic [31:0] push_val [16];

    always #5 clk = ~clk;

    fifo_burst_reader #(.WIDTH(32), .LEN_WIDTH(8)) dut (
        .i_clock     (clk),
        .i_areset    (areset),
        .i_start     (start),
        .i_burst_len (burst_len),
        .o_busy      (busy),
        .o_done      (done),
        .i_fifo_empty(fifo_empty),
        .o_fifo_rd_en(fifo_rd_en),
        .i_fifo_data (fifo_data),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_data    (m_data),
        .o_m_last    (m_last)
    );

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (tb_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic flush();
        @(negedge clk);
        tb_flush = 1'b1;
        @(negedge clk);
        tb_flush = 1'b0;
    endtask

    // Cycle c=0 is the start cycle; bit c of each mask is the expected value in cycle T+c.
    task automatic run_seq(input string tag, input int n, input logic [7:0] len,
                           input logic [7:0] alt_len, input logic [15:0] st,
                           input logic [15:0] rdy, input logic [15:0] psh,
                           input logic [15:0] e_rd, input logic [15:0] e_v,
                           input logic [15:0] e_last, input logic [15:0] e_busy,
                           input logic [15:0] e_done);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start     = st[c];
            burst_len = (c == 0) ? len : alt_len;
            m_ready   = rdy[c];
            if (psh[c]) push(push_val[c]);
            #1;
            chk($sformatf("%s rd_en c%0d", tag, c), {31'd0, fifo_rd_en}, {31'd0, e_rd[c]});
            chk($sformatf("%s m_valid c%0d", tag, c), {31'd0, m_valid}, {31'd0, e_v[c]});
            chk($sformatf("%s m_last c%0d", tag, c), {31'd0, m_last}, {31'd0, e_last[c]});
            chk($sformatf("%s busy c%0d", tag, c), {31'd0, busy}, {31'd0, e_busy[c]});
            chk($sformatf("%s done c%0d", tag, c), {31'd0, done}, {31'd0, e_done[c]});
            if (e_v[c]) chk($sformatf("%s m_data c%0d", tag, c), m_data, exp_dat[c]);
        end
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"},    {31'd0, busy},       32'd0);
        chk({tag, " done"},    {31'd0, done},       32'd0);
        chk({tag, " rd_en"},   {31'd0, fifo_rd_en}, 32'd0);
        chk({tag, " m_valid"}, {31'd0, m_valid},    32'd0);
        chk({tag, " m_last"},  {31'd0, m_last},     32'd0);
        chk({tag, " m_data"},  m_data,              32'd0);
    endtask

    initial begin
        areset    = 1'b1;
        start     = 1'b0;
        burst_len = 8'd0;
        m_ready   = 1'b0;
        fifo_data = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        areset = 1'b0;

        // 1: back-to-back burst of 4 with m_ready high
        push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
        exp_dat[3] = 32'hA0; exp_dat[4] = 32'hA1; exp_dat[5] = 32'hA2; exp_dat[6] = 32'hA3;
        run_seq("t1", 9, 8'd4, 8'd0, 16'h0001, 16'hFFFF, 16'h0000,
                16'b0000_0000_0001_1110, 16'b0000_0000_0111_1000,
                16'b0000_0000_0100_0000, 16'b0000_0000_0111_1110,
                16'b0000_0000_1000_0000);

        // 2: m_ready toggling; pops stop while the skid buffer is committed full
        flush();
        push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
        exp_dat[3] = 32'hA0; exp_dat[4] = 32'hA1; exp_dat[5] = 32'hA1; exp_dat[6] = 32'hA1;
        exp_dat[7] = 32'hA2; exp_dat[8] = 32'hA2; exp_dat[9] = 32'hA3;
        run_seq("t2", 11, 8'd4, 8'd0, 16'h0001, 16'b0000_0111_0100_1111, 16'h0000,
                16'b0000_0000_0100_1110, 16'b0000_0011_1111_1000,
                16'b0000_0010_0000_0000, 16'b0000_0011_1111_1110,
                16'b0000_0100_0000_0000);

        // 3: FIFO empty at start, words trickle in at T+5 and T+9
        flush();
        push_val[5] = 32'h11; push_val[9] = 32'h22;
        exp_dat[7] = 32'h11; exp_dat[11] = 32'h22;
        run_seq("t3", 13, 8'd2, 8'd0, 16'h0001, 16'hFFFF, 16'b0000_0010_0010_0000,
                16'b0000_0010_0010_0000, 16'b0000_1000_1000_0000,
                16'b0000_1000_0000_0000, 16'b0000_1111_1111_1110,
                16'b0001_0000_0000_0000);

        // 4: zero-length burst
        flush();
        run_seq("t4", 3, 8'd0, 8'd0, 16'h0001, 16'hFFFF, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'b0000_0000_0000_0010);

        // 5: reset after the third handshake of an 8-word burst
        flush();
        for (int i = 0; i < 8; i++) push(32'hB0 + 32'(i));
        exp_dat[3] = 32'hB0; exp_dat[4] = 32'hB1; exp_dat[5] = 32'hB2;
        run_seq("t5", 6, 8'd8, 8'd0, 16'h0001, 16'hFFFF, 16'h0000,
                16'b0000_0000_0011_1110, 16'b0000_0000_0011_1000,
                16'h0000, 16'b0000_0000_0011_1110, 16'h0000);
        @(negedge clk);
        areset = 1'b1;
        #1;
        chk_all_zero("t5 async reset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t5 no done %0d", i), {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        areset = 1'b0;
        flush();
        push(32'hC5);
        exp_dat[3] = 32'hC5;
        run_seq("t5 post", 6, 8'd1, 8'd0, 16'h0001, 16'hFFFF, 16'h0000,
                16'b0000_0000_0000_0010, 16'b0000_0000_0000_1000,
                16'b0000_0000_0000_1000, 16'b0000_0000_0000_1110,
                16'b0000_0000_0001_0000);

        // 6: start during RUN and DONE is ignored; extra FIFO words must stay unread
        flush();
        for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i));
        exp_dat[3] = 32'hD0; exp_dat[4] = 32'hD1; exp_dat[5] = 32'hD2;
        run_seq("t6", 8, 8'd3, 8'd5, 16'b0000_0000_0100_1001, 16'hFFFF, 16'h0000,
                16'b0000_0000_0000_1110, 16'b0000_0000_0011_1000,
                16'b0000_0000_0010_0000, 16'b0000_0000_0011_1110,
                16'b0000_0000_0100_0000);
        chk("t6 words left in fifo", 32'(wr_ptr - rd_ptr), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side master for the team's synchronous FIFO. On a start command it pops a programmed number of words from the FIFO read port, absorbing the FIFO's 1-cycle read latency. It presents the words downstream on a valid/ready stream, marking the final word with last. It sits between a FIFO's output and any streaming consumer (DMA, serializer), and is the consuming counterpart to the FIFO writer.

Parameters:
WIDTH, 32, data word width in bits.
LEN_WIDTH, 8, width of burst length; max burst = 2^LEN_WIDTH - 1 words.

Ports:
clock  input  1  rising-edge clock for all state.
areset  input  1  asynchronous, active-high reset; clears all state immediately.
start  input  1  burst request; sampled only in IDLE.
burst_len  input  LEN_WIDTH  words to read; sampled with start.
busy  output  1  high while a burst is in progress (RUN).
done  output  1  one-cycle pulse when the burst completes.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  pop strobe to the FIFO.
fifo_data  input  WIDTH  FIFO read data, valid in the cycle after fifo_rd_en.
m_valid  output  1  output word valid.
m_ready  input  1  downstream accepts the word.
m_data  output  WIDTH  output word.
m_last  output  1  high with the final word of the burst.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, fifo_rd_en=0, m_valid=0, m_last=0, m_data=0; counters and buffer cleared. Mid-burst reset discards in-flight and buffered words with no done pulse. The FIFO may have lost popped words; this is acceptable.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with burst_len!=0: latch issue_cnt=burst_len and out_cnt=burst_len, go to RUN next cycle.
  - start=1 with burst_len==0: go to DONE with no reads.
  - start=0: stay in IDLE.
- RUN: start is ignored. busy=1.
- DONE: lasts one cycle; done=1, busy=0; then returns to IDLE. start is ignored in DONE.
- Output buffer: 2 entries (skid). occ = entries held, 0..2. inflight = 1 if fifo_rd_en was high in the previous cycle.
- Pop rule (combinational): fifo_rd_en = RUN && !fifo_empty && issue_cnt!=0 && (occ + inflight - pop) < 2, where pop = m_valid && m_ready. Each rd_en decrements issue_cnt.
- Capture: fifo_data is written into the buffer at the clock edge ending the cycle after rd_en. m_valid rises the following cycle. Minimum latency is start cycle T → rd_en T+1 → m_valid T+3.
- Throughput: with m_ready held high and the FIFO non-empty, exactly 1 word per cycle is sustained.
- Handshake:
  - m_data and m_last hold stable while m_valid && !m_ready.
  - m_valid never drops without a handshake.
  - Words are delivered in FIFO order.
- m_last = m_valid && out_cnt==1. Each handshake decrements out_cnt.
- Completion: the handshake with m_last=1 moves RUN→DONE, so done pulses in the next cycle.
- Empty: while fifo_empty=1, no pop occurs and the burst stalls indefinitely with busy=1. Buffered words still drain.
- fifo_rd_en is never asserted when fifo_empty=1, when issue_cnt==0, or outside RUN.
- Counters are LEN_WIDTH wide and never wrap, because decrements are gated at 0.

Test Plan:
1. FIFO preloaded 0xA0,0xA1,0xA2,0xA3; burst_len=4, start at T, m_ready=1 → fifo_rd_en high T+1..T+4; m_valid T+3..T+6 with data A0..A3; m_last only at T+6; done=1 at T+7 only; busy T+1..T+6.
2. Same preload; m_ready toggles 1,0,0,1,0,1… → rd_en never issued with occ+inflight already 2; m_data held while stalled; all 4 words delivered in order, none duplicated; m_last on 0xA3 only.
3. FIFO empty at start, burst_len=2; push 0x11 at T+5 and 0x22 at T+9 → no rd_en before T+5; m_valid carries 0x11 then 0x22 (last); busy=1 throughout; done after the 0x22 handshake.
4. start with burst_len=0 → done pulse at T+1, busy stays 0, no rd_en, no m_valid.
5. burst_len=8, areset asserted after the 3rd handshake → all outputs 0 asynchronously; no done; a new burst_len=1 start after release completes normally with done.
6. Second start pulse during RUN with burst_len=5 → ignored; first burst completes with its original length; busy=0 in DONE.
